// File: rtl/ilas_parser.sv
// ilas_parser: tracks the JESD204B initial lane alignment sequence, checks its markers,
// captures and checksums the link configuration, and flags when user data starts.
module ilas_parser #(
    parameter int PARALLEL_OCTETS = 4,
    parameter int F = 2,
    parameter int K = 16,
    parameter int ILAS_MF = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           valid_i,
    input  logic [8*PARALLEL_OCTETS-1:0]   data_i,
    input  logic [PARALLEL_OCTETS-1:0]     charisk_i,
    output logic                           data_ready_o,
    output logic [111:0]                   cfg_o,
    output logic                           cfg_valid_o,
    output logic [2:0]                     err_o
);
    localparam int P = PARALLEL_OCTETS;
    localparam int MF_BEATS = F * K / P;
    localparam int BW = MF_BEATS > 1 ? $clog2(MF_BEATS) : 1;

    if (!(P == 2 || P == 4 || P == 8) || F * K < 16 || (F * K) % P != 0 ||
        ILAS_MF < 2 || ILAS_MF > 8) begin : g_bad_params
        $error("ilas_parser: illegal parameter combination");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ILAS, ST_DATA, ST_ERR} state_t;

    state_t           state;
    logic [BW-1:0]    beat_cnt;
    logic [2:0]       mf_cnt;
    logic [13:0][7:0] cfg_buf;
    logic [13:0][7:0] cfg_nxt;
    logic [7:0]       sum;
    logic [2:0]       err_nxt;
    logic             first, last, r_ok, q_ok, a_ok;
    int               idx;

    assign r_ok = charisk_i[0] && data_i[7:0] == 8'h1C;
    assign q_ok = charisk_i[1] && data_i[15:8] == 8'h9C;
    assign a_ok = charisk_i[P-1] && data_i[8*P-1 -: 8] == 8'h7C;
    assign first = beat_cnt == '0;
    assign last = beat_cnt == BW'(MF_BEATS - 1);

    // Config octets land wherever they fall in the beat; the checksum sees this beat's octets too.
    always_comb begin
        cfg_nxt = cfg_buf;
        idx = 0;
        for (int n = 0; n < P; n++) begin
            idx = int'(beat_cnt) * P + n;
            if (mf_cnt == 3'd1 && idx >= 2 && idx <= 15) cfg_nxt[4'(idx - 2)] = data_i[8*n +: 8];
        end
        sum = cfg_nxt[0] + 8'(cfg_nxt[1][7:4]) + 8'(cfg_nxt[1][3:0]) + 8'(cfg_nxt[2][6])
            + 8'(cfg_nxt[2][5]) + 8'(cfg_nxt[2][4:0]) + 8'(cfg_nxt[3][7]) + 8'(cfg_nxt[3][4:0])
            + cfg_nxt[4] + 8'(cfg_nxt[5][4:0]) + cfg_nxt[6] + 8'(cfg_nxt[7][7:6])
            + 8'(cfg_nxt[7][4:0]) + 8'(cfg_nxt[8][7:5]) + 8'(cfg_nxt[8][4:0])
            + 8'(cfg_nxt[9][7:5]) + 8'(cfg_nxt[9][4:0]) + 8'(cfg_nxt[10][7])
            + 8'(cfg_nxt[10][4:0]) + cfg_nxt[11] + cfg_nxt[12];
        err_nxt[0] = (first && mf_cnt != 3'd0 && !r_ok) || (last && !a_ok);
        err_nxt[1] = mf_cnt == 3'd1 && first && !q_ok;
        err_nxt[2] = mf_cnt == 3'd1 && last && sum != cfg_nxt[13];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            mf_cnt       <= '0;
            cfg_buf      <= '0;
            cfg_o        <= '0;
            cfg_valid_o  <= 1'b0;
            data_ready_o <= 1'b0;
            err_o        <= '0;
        end else if (!valid_i) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            mf_cnt       <= '0;
            data_ready_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (r_ok) begin
                    state       <= ST_ILAS;
                    beat_cnt    <= BW'(1);
                    mf_cnt      <= '0;
                    err_o       <= '0;
                    cfg_valid_o <= 1'b0;
                end
                ST_ILAS: begin
                    cfg_buf <= cfg_nxt;
                    if (|err_nxt) begin
                        err_o <= err_o | err_nxt;
                        state <= ST_ERR;
                    end else if (last) begin
                        beat_cnt <= '0;
                        mf_cnt   <= mf_cnt + 3'd1;
                        if (mf_cnt == 3'd1) begin
                            cfg_o       <= cfg_nxt;
                            cfg_valid_o <= 1'b1;
                        end
                        if (mf_cnt == 3'(ILAS_MF - 1)) begin
                            state        <= ST_DATA;
                            data_ready_o <= 1'b1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ilas_parser.sv
// tb_ilas_parser: scenario tasks drive ILAS streams; expected {data_ready, cfg_valid, err}
// per beat is queued at drive time and compared when the beat's result appears.
module tb_ilas_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v4 = 1'b0, v8 = 1'b0;
    logic [31:0] d4 = '0;
    logic [3:0]  k4 = '0;
    logic [63:0] d8 = '0;
    logic [7:0]  k8 = '0;
    logic dr4, cv4, dr8, cv8;
    logic [2:0] e4, e8;
    logic [111:0] cfg4, cfg8;

    ilas_parser dut4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .data_i(d4), .charisk_i(k4),
        .data_ready_o(dr4), .cfg_o(cfg4), .cfg_valid_o(cv4), .err_o(e4)
    );
    ilas_parser #(.PARALLEL_OCTETS(8), .F(1), .K(32), .ILAS_MF(4)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v8), .data_i(d8), .charisk_i(k8),
        .data_ready_o(dr8), .cfg_o(cfg8), .cfg_valid_o(cv8), .err_o(e8)
    );

    int total = 0;
    int bad = 0;
    logic [4:0] exp_q[$];
    logic [7:0] st_d[128];
    logic       st_k[128];
    logic [13:0][7:0] cfg;
    logic [4:0] got, want;

    function automatic logic [7:0] ref_sum(input logic [13:0][7:0] c);
        int s;
        s = c[0] + c[1][7:4] + c[1][3:0] + c[2][6] + c[2][5] + c[2][4:0] + c[3][7] + c[3][4:0]
          + c[4] + c[5][4:0] + c[6] + c[7][7:6] + c[7][4:0] + c[8][7:5] + c[8][4:0]
          + c[9][7:5] + c[9][4:0] + c[10][7] + c[10][4:0] + c[11] + c[12];
        return 8'(s % 256);
    endfunction

    // Four 32-octet multiframes: /R/ first, /A/ last, /Q/ + config in the second one.
    task automatic build();
        for (int c = 0; c < 13; c++) cfg[c] = 8'($urandom);
        cfg[13] = ref_sum(cfg);
        for (int i = 0; i < 128; i++) begin
            int o;
            o = i % 32;
            st_d[i] = 8'($urandom_range(0, 255));
            st_k[i] = 1'b0;
            if (o == 0) begin st_d[i] = 8'h1C; st_k[i] = 1'b1; end
            if (o == 31) begin st_d[i] = 8'h7C; st_k[i] = 1'b1; end
            if (i == 33) begin st_d[i] = 8'h9C; st_k[i] = 1'b1; end
            if (i >= 34 && i <= 47) st_d[i] = cfg[i-34];
        end
    endtask

    task automatic step4(input int b, input logic v, input logic [4:0] e);
        v4 = v;
        for (int n = 0; n < 4; n++) begin
            if (b < 32) begin d4[8*n +: 8] = st_d[b*4+n]; k4[n] = st_k[b*4+n]; end
            else begin d4[8*n +: 8] = 8'($urandom); k4[n] = 1'($urandom); end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input int b, input logic v, input logic [4:0] e);
        v8 = v;
        for (int n = 0; n < 8; n++) begin
            if (b < 16) begin d8[8*n +: 8] = st_d[b*8+n]; k8[n] = st_k[b*8+n]; end
            else begin d8[8*n +: 8] = 8'($urandom); k8[n] = 1'($urandom); end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({dr4, cv4, e4, cfg4} !== '0) begin
            bad++; $display("FAIL reset4 got=%b/%b/%b want=0/0/000", dr4, cv4, e4);
        end
        total++;
        if ({dr8, cv8, e8, cfg8} !== '0) begin
            bad++; $display("FAIL reset8 got=%b/%b/%b want=0/0/000", dr8, cv8, e8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        build();
        for (int i = 0; i < 36; i++) begin
            step4(i, 1'b1, {i >= 31, i >= 15, 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL clean beat %0d got=%b want=%b", i, got, want); end
        end
        total++;
        if (cfg4 !== cfg) begin bad++; $display("FAIL clean_cfg got=%h want=%h", cfg4, cfg); end
    endtask

    task automatic test_bad_chk();
        step4(0, 1'b0, 5'b0_1_000);
        got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL chk_idle got=%b want=%b", got, want); end
        build();
        st_d[47] = st_d[47] + 8'd1;
        for (int i = 0; i < 32; i++) begin
            step4(i, 1'b1, {2'b00, i >= 15 ? 3'b100 : 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL chk beat %0d got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_marker();
        step4(0, 1'b0, 5'b0_0_100);
        got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL mk_idle got=%b want=%b", got, want); end
        build();
        st_d[23*4+3] = 8'h7D;
        for (int i = 0; i < 32; i++) begin
            step4(i, 1'b1, {1'b0, i >= 15, i >= 23 ? 3'b001 : 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL marker beat %0d got=%b want=%b", i, got, want); end
        end
        step4(0, 1'b0, 5'b0_1_001);
        got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL mk_drop got=%b want=%b", got, want); end
        build();
        for (int i = 0; i < 32; i++) begin
            step4(i, 1'b1, {i >= 31, i >= 15, 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL mk_retry beat %0d got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_q();
        step4(0, 1'b0, 5'b0_1_000);
        got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL q_idle got=%b want=%b", got, want); end
        build();
        st_d[33] = 8'h00;
        st_k[33] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step4(i, 1'b1, {2'b00, i >= 8 ? 3'b010 : 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL q beat %0d got=%b want=%b", i, got, want); end
        end
        v4 = 1'b0;
    endtask

    task automatic test_p8();
        build();
        for (int i = 0; i < 18; i++) begin
            step8(i, 1'b1, {i >= 15, i >= 7, 3'b000});
            got = {dr8, cv8, e8}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL p8 beat %0d got=%b want=%b", i, got, want); end
        end
        total++;
        if (cfg8 !== cfg) begin bad++; $display("FAIL p8_cfg got=%h want=%h", cfg8, cfg); end
        v8 = 1'b0;
    endtask

    task automatic test_drop();
        build();
        for (int i = 0; i < 11; i++) begin
            step4(i, i < 10, 5'b0_0_000);
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL drop10 beat %0d got=%b want=%b", i, got, want); end
        end
        for (int i = 0; i < 21; i++) begin
            step4(i, i < 20, {1'b0, i >= 15, 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL drop20 beat %0d got=%b want=%b", i, got, want); end
        end
        for (int i = 0; i < 34; i++) begin
            step4(i, 1'b1, {i >= 31, i >= 15, 3'b000});
            got = {dr4, cv4, e4}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL drop_full beat %0d got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({dr4, cv4, e4, cfg4} !== '0) begin
            bad++; $display("FAIL async4 got=%b/%b/%b want=0/0/000", dr4, cv4, e4);
        end
        total++;
        if ({dr8, cv8, e8, cfg8} !== '0) begin
            bad++; $display("FAIL async8 got=%b/%b/%b want=0/0/000", dr8, cv8, e8);
        end
        v4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bad_chk();
        test_marker();
        test_q();
        test_p8();
        test_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ilas_parser.md
ILAS_PARSER -- requirements
Module: ilas_parser

Interface
REQ-001 SHALL have parameter PARALLEL_OCTETS, default 4, octets per beat; legal values 2, 4, 8.
REQ-002 SHALL have parameter F, default 2, octets per frame.
REQ-003 SHALL have parameter K, default 16, frames per multiframe; F*K SHALL be >= 16 and a multiple of PARALLEL_OCTETS (elaboration error otherwise).
REQ-004 SHALL have parameter ILAS_MF, default 4, ILAS multiframes expected; legal 2..8.
REQ-005 clk_i  input  1  single clock; all logic rising-edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 valid_i  input  1  lane synchronised (CGS done); low aborts parsing.
REQ-008 data_i  input  8*PARALLEL_OCTETS  octet n at bits [8n+7:8n], octet 0 earliest.
REQ-009 charisk_i  input  PARALLEL_OCTETS  bit n high = octet n is a K character.
REQ-010 data_ready_o  output  1  user data follows ILAS.
REQ-011 cfg_o  output  112  14 config octets, octet c at bits [8c+7:8c].
REQ-012 cfg_valid_o  output  1  cfg_o captured and checksum correct.
REQ-013 err_o  output  3  sticky flags {chk_err, q_err, marker_err}.

Function
REQ-014 SHALL define MF_BEATS = F*K/PARALLEL_OCTETS; multiframe octet index = beat_cnt*PARALLEL_OCTETS + n.
REQ-015 SHALL implement states ST_IDLE, ST_ILAS, ST_DATA, ST_ERR; all outputs registered.
REQ-016 ST_IDLE: on beat with valid_i=1, charisk_i[0]=1, data_i[7:0]=0x1C (/R/) -> ST_ILAS; that beat is mf_cnt=0, beat_cnt=0; err_o cleared, cfg_valid_o cleared on the same edge.
REQ-017 ST_ILAS: beat_cnt increments each beat, wraps at MF_BEATS-1 and increments mf_cnt.
REQ-018 ST_ILAS beat_cnt=0 with mf_cnt>0: octet 0 not /R/ (K, 0x1C) -> marker_err, -> ST_ERR.
REQ-019 ST_ILAS beat_cnt=MF_BEATS-1: octet PARALLEL_OCTETS-1 not /A/ (K, 0x7C) -> marker_err, -> ST_ERR.
REQ-020 mf_cnt=1: multiframe octet 1 not /Q/ (K, 0x9C) -> q_err, -> ST_ERR.
REQ-021 mf_cnt=1: multiframe octets 2..15 SHALL be stored to config octets 0..13, any beat alignment.
REQ-022 Checksum at end of mf_cnt=1: sum mod 256 of fields DID=c0, ADJCNT=c1[7:4], BID=c1[3:0], ADJDIR=c2[6], PHADJ=c2[5], LID=c2[4:0], SCR=c3[7], L=c3[4:0], F=c4, K=c5[4:0], M=c6, CS=c7[7:6], N=c7[4:0], SUBCLASSV=c8[7:5], NP=c8[4:0], JESDV=c9[7:5], S=c9[4:0], HD=c10[7], CF=c10[4:0], RES1=c11, RES2=c12; compared with c13.
REQ-023 Checksum match -> cfg_valid_o=1 one cycle after the last beat of mf_cnt=1; mismatch -> chk_err, -> ST_ERR.
REQ-024 Marker/Q/checksum errors in the same beat SHALL all set their flags.
REQ-025 Last beat of mf_cnt=ILAS_MF-1 with valid /A/ -> ST_DATA; data_ready_o=1 the following cycle.
REQ-026 ST_DATA: data_ready_o held 1; K characters not checked; cfg_o, cfg_valid_o held.
REQ-027 valid_i=0 in any state -> ST_IDLE next edge; data_ready_o=0, counters cleared; cfg_o, cfg_valid_o, err_o retained.
REQ-028 ST_ERR: data_ready_o=0; exit only via valid_i=0.
REQ-029 valid_i=0 during ST_ILAS SHALL discard partial config (cfg_valid_o stays 0).

Reset
REQ-030 rst_ni=0 SHALL asynchronously force ST_IDLE, data_ready_o=0, cfg_valid_o=0, err_o=0, cfg_o=0, counters 0.
REQ-031 Release SHALL take effect on the first clk_i edge with rst_ni=1; reset mid-ILAS discards all progress.

Verification (P=4, F=2, K=16, ILAS_MF=4, MF_BEATS=8)
REQ-032 Clean 32-beat ILAS, valid checksum -> cfg_valid_o=1 at cycle 16, data_ready_o=1 at cycle 32, err_o=000.
REQ-033 c13 corrupted (+1) -> err_o=100, cfg_valid_o=0, data_ready_o never rises.
REQ-034 /A/ replaced by 0x7D at beat 23 -> err_o=001 at cycle 24, ST_ERR; valid_i low then fresh ILAS -> data_ready_o=1, err_o=000.
REQ-035 /Q/ missing in beat 8 -> err_o=010; ILAS with P=8, F=1, K=32 -> cfg_o correct despite config spanning 2 beats.
REQ-036 valid_i dropped at beat 20, then full ILAS -> data_ready_o=1 exactly 32 cycles after new /R/.
REQ-037 rst_ni asserted asynchronously mid-ST_DATA -> all outputs 0 before next clk_i edge.
